// File: rtl/router_reg_if.sv
// Byte-stream and FSM-strobe bundle between the router FSM/input side and the
// router_reg datapath stage. The master drives bytes and strobes; the slave returns dout and status.
interface router_reg_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] datain;
  logic [DATA_WIDTH-1:0] dout;
  logic                  pkt_valid;
  logic                  fifo_full;
  logic                  detect_add;
  logic                  lfd_state;
  logic                  ld_state;
  logic                  laf_state;
  logic                  full_state;
  logic                  rst_int_reg;
  logic                  parity_done;
  logic                  low_packet_valid;
  logic                  err;

  modport master (
    output datain, pkt_valid, fifo_full, detect_add, lfd_state, ld_state,
           laf_state, full_state, rst_int_reg,
    input  dout, parity_done, low_packet_valid, err
  );

  modport slave (
    input  datain, pkt_valid, fifo_full, detect_add, lfd_state, ld_state,
           laf_state, full_state, rst_int_reg,
    output dout, parity_done, low_packet_valid, err
  );
endinterface

// File: rtl/router_reg.sv
// Router datapath register: header capture, byte forwarding with one-byte
// hold across a full FIFO, running XOR parity check and FSM status flags.
module router_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  router_reg_if.slave  bus
);
  logic [DATA_WIDTH-1:0] r_dout, r_header, r_full_byte, r_int_par, r_pkt_par;
  logic                  r_parity_done, r_lpv, r_err;

  // Strobes are one-hot from the FSM; if not, earlier states win.
  logic w_det, w_lfd, w_ld, w_laf;
  assign w_det = bus.detect_add;
  assign w_lfd = bus.lfd_state & ~w_det;
  assign w_ld  = bus.ld_state  & ~w_det & ~bus.lfd_state;
  assign w_laf = bus.laf_state & ~w_det & ~bus.lfd_state & ~bus.ld_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dout      <= '0;
      r_header    <= '0;
      r_full_byte <= '0;
    end else begin
      if (w_det && bus.pkt_valid) r_header <= bus.datain;
      if (w_lfd)                  r_dout <= r_header;
      else if (w_ld) begin
        // The byte arriving as the FIFO fills is parked and replayed by laf.
        if (!bus.fifo_full) r_dout      <= bus.datain;
        else                r_full_byte <= bus.datain;
      end else if (w_laf)         r_dout <= r_full_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_int_par <= '0;
      r_pkt_par <= '0;
    end else begin
      if (w_det)                                        r_int_par <= '0;
      else if (w_lfd)                                   r_int_par <= r_int_par ^ r_header;
      else if (w_ld && bus.pkt_valid && !bus.full_state) r_int_par <= r_int_par ^ bus.datain;

      if (w_det)                         r_pkt_par <= '0;
      else if (w_ld && !bus.pkt_valid)  r_pkt_par <= bus.datain;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_parity_done <= 1'b0;
      r_lpv         <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      if (w_det) r_parity_done <= 1'b0;
      else if ((w_ld && !bus.fifo_full && !bus.pkt_valid) ||
               (w_laf && r_lpv && !r_parity_done))
        r_parity_done <= 1'b1;

      if (bus.rst_int_reg)              r_lpv <= 1'b0;
      else if (w_ld && !bus.pkt_valid)  r_lpv <= 1'b1;

      // err stays visible until the next packet's header is loaded.
      if (bus.rst_int_reg) r_err <= (r_int_par != r_pkt_par);
      else if (w_lfd)      r_err <= 1'b0;
    end
  end

  assign bus.dout             = r_dout;
  assign bus.parity_done      = r_parity_done;
  assign bus.low_packet_valid = r_lpv;
  assign bus.err              = r_err;
endmodule
